// File: rtl/traffic_pkg.sv
// Shared constants for the intersection controller: phase codes,
// lamp patterns and default phase durations.
package traffic_pkg;

    localparam logic [2:0] ALLRED_A  = 3'd0;
    localparam logic [2:0] NS_GREEN  = 3'd1;
    localparam logic [2:0] NS_YELLOW = 3'd2;
    localparam logic [2:0] ALLRED_B  = 3'd3;
    localparam logic [2:0] EW_GREEN  = 3'd4;
    localparam logic [2:0] EW_YELLOW = 3'd5;
    localparam logic [2:0] PED_WALK  = 3'd6;
    localparam logic [2:0] FLASH     = 3'd7;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic STEP_LOAD = 1'b0;
    localparam logic STEP_WAIT = 1'b1;

    localparam int DEF_ALLRED   = 2;
    localparam int DEF_GREEN_NS = 30;
    localparam int DEF_GREEN_EW = 20;
    localparam int DEF_YELLOW   = 3;
    localparam int DEF_WALK     = 10;
    localparam int DEF_FLASH    = 1;

endpackage

// File: rtl/traffic_sequencer_lamp_decode.sv
// Combinational lamp pattern for a phase; the caller registers the result.
module lamp_decode
    import traffic_pkg::*;
(
    input  logic [2:0] phase,
    input  logic       flash_on,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       walk
);

    always_comb begin
        ns_lamp = LAMP_RED;
        ew_lamp = LAMP_RED;
        walk    = 1'b0;
        case (phase)
            NS_GREEN:  ns_lamp = LAMP_GRN;
            NS_YELLOW: ns_lamp = LAMP_YEL;
            EW_GREEN:  ew_lamp = LAMP_GRN;
            EW_YELLOW: ew_lamp = LAMP_YEL;
            PED_WALK:  walk = 1'b1;
            FLASH: begin
                ns_lamp = flash_on ? LAMP_YEL : LAMP_OFF;
                ew_lamp = flash_on ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/traffic_sequencer.sv
// Intersection phase sequencer; drives the lamps and loads the external
// seconds timer once per phase, advancing on its completion pulse.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int T_ALLRED   = DEF_ALLRED,
    parameter int T_GREEN_NS = DEF_GREEN_NS,
    parameter int T_GREEN_EW = DEF_GREEN_EW,
    parameter int T_YELLOW   = DEF_YELLOW,
    parameter int T_WALK     = DEF_WALK,
    parameter int T_FLASH    = DEF_FLASH
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ped_req,
    input  logic        night_mode,
    input  logic        timer_done,
    output logic        timer_load,
    output logic [15:0] timer_seconds,
    output logic [2:0]  ns_lamp,
    output logic [2:0]  ew_lamp,
    output logic        walk,
    output logic [2:0]  phase
);

    logic [2:0] state;
    logic [2:0] nxt_state;
    logic       step;
    logic       ped_pend;
    logic       flash_on;
    logic       nxt_flash;
    logic       issue;
    logic       done_ok;
    logic [2:0] dec_ns;
    logic [2:0] dec_ew;
    logic       dec_walk;

    function automatic logic [15:0] dur(input logic [2:0] p);
        case (p)
            NS_GREEN:            return 16'(T_GREEN_NS);
            EW_GREEN:            return 16'(T_GREEN_EW);
            NS_YELLOW, EW_YELLOW: return 16'(T_YELLOW);
            PED_WALK:            return 16'(T_WALK);
            FLASH:               return 16'(T_FLASH);
            default:             return 16'(T_ALLRED);
        endcase
    endfunction

    // The cycle showing timer_load=1 is the LOAD cycle; done is ignored there.
    assign done_ok = (step == STEP_WAIT) && !timer_load && timer_done;

    always_comb begin
        nxt_state = state;
        nxt_flash = flash_on;
        issue     = 1'b0;
        if (step == STEP_LOAD) begin
            issue = 1'b1;
        end else if (done_ok) begin
            issue = 1'b1;
            case (state)
                ALLRED_A:  nxt_state = night_mode ? FLASH : NS_GREEN;
                NS_GREEN:  nxt_state = NS_YELLOW;
                NS_YELLOW: nxt_state = ALLRED_B;
                ALLRED_B:  nxt_state = night_mode ? FLASH : EW_GREEN;
                EW_GREEN:  nxt_state = EW_YELLOW;
                EW_YELLOW: nxt_state = ped_pend ? PED_WALK : ALLRED_A;
                PED_WALK:  nxt_state = ALLRED_A;
                FLASH: begin
                    if (night_mode) nxt_flash = ~flash_on;
                    else            nxt_state = ALLRED_A;
                end
                default:   nxt_state = ALLRED_A;
            endcase
        end
    end

    lamp_decode u_dec (
        .phase    (nxt_state),
        .flash_on (nxt_flash),
        .ns_lamp  (dec_ns),
        .ew_lamp  (dec_ew),
        .walk     (dec_walk)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= ALLRED_A;
            step          <= STEP_LOAD;
            ped_pend      <= 1'b0;
            flash_on      <= 1'b0;
            timer_load    <= 1'b0;
            timer_seconds <= 16'd0;
            ns_lamp       <= LAMP_RED;
            ew_lamp       <= LAMP_RED;
            walk          <= 1'b0;
            phase         <= ALLRED_A;
        end else begin
            state      <= nxt_state;
            step       <= STEP_WAIT;
            flash_on   <= nxt_flash;
            timer_load <= issue;
            if (issue) timer_seconds <= dur(nxt_state);
            ns_lamp    <= dec_ns;
            ew_lamp    <= dec_ew;
            walk       <= dec_walk;
            phase      <= nxt_state;
            // Entering the walk phase consumes the request; a same-cycle press is lost.
            if (issue && nxt_state == PED_WALK && state != PED_WALK)
                ped_pend <= 1'b0;
            else if (ped_req && state != PED_WALK)
                ped_pend <= 1'b1;
        end
    end

endmodule
